kmeans_regfile: RTL and testbench

Host-facing register file and run sequencer for the k-means core. It is the responder to the clustering controller's register-number/write interface. It holds the initial and final centroids, the point-RAM window and status. It issues the one-cycle start pulse to the controller and converts the controller's completion pulse into a sticky host interrupt. It also provides a host path for loading point RAM before a run.

---
 rtl/kmeans_regfile.sv | 155 +++++++++++++++
 tb/tb_kmeans_regfile.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_regfile.sv
// Host register file and run sequencer for the k-means core: centroid storage,
// point-RAM window/loader, go pulse generation and sticky completion interrupt.
module kmeans_regfile #(
  parameter int unsigned REG_W    = 4,
  parameter int unsigned DATA_W   = 91,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned CENT_NUM = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  host_addr,
  input  logic              host_wr_en,
  input  logic              host_rd_en,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic [REG_W-1:0]  ctl_reg_num,
  input  logic              ctl_reg_write,
  input  logic [DATA_W-1:0] ctl_wdata,
  output logic [DATA_W-1:0] ctl_rdata,
  input  logic              ctl_interrupt,
  output logic              go,
  output logic [ADDR_W-1:0] first_ram_addr,
  output logic [ADDR_W-1:0] last_ram_addr,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wr_strobe,
  output logic              irq,
  output logic              busy
);

  localparam int unsigned NREGS = 2 ** REG_W;

  localparam logic [REG_W-1:0] R_STATUS   = REG_W'(0);
  localparam logic [REG_W-1:0] R_GO       = REG_W'(1);
  localparam logic [REG_W-1:0] R_CENT0    = REG_W'(2);
  localparam logic [REG_W-1:0] R_CENT_END = REG_W'(CENT_NUM + 2);
  localparam logic [REG_W-1:0] R_RAM_ADDR = REG_W'(10);
  localparam logic [REG_W-1:0] R_RAM_DATA = REG_W'(11);
  localparam logic [REG_W-1:0] R_FIRST    = REG_W'(12);
  localparam logic [REG_W-1:0] R_LAST     = REG_W'(13);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] cent [CENT_NUM];
  logic [ADDR_W-1:0] ram_addr;
  logic              err;
  logic              done;

  logic [DATA_W-1:0] view [NREGS];
  logic              host_cent;
  logic              collide;
  logic              locked_reg;

  // Read view of every register slot; unmapped slots and GO read as zero.
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) view[i] = '0;
    view[R_STATUS] = DATA_W'({err, done, busy});
    for (int k = 0; k < int'(CENT_NUM); k++) view[REG_W'(k + 2)] = cent[k];
    view[R_RAM_ADDR] = DATA_W'(ram_addr);
    view[R_RAM_DATA] = ram_wr_data;
    view[R_FIRST]    = DATA_W'(first_ram_addr);
    view[R_LAST]     = DATA_W'(last_ram_addr);
  end

  assign ctl_rdata = view[ctl_reg_num];

  // A controller write to the same centroid silently overrides the host write.
  assign host_cent  = (host_addr >= R_CENT0) && (host_addr < R_CENT_END);
  assign collide    = host_wr_en && ctl_reg_write && host_cent && (ctl_reg_num == host_addr);
  assign locked_reg = (host_addr >= R_GO) && (host_addr <= R_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int k = 0; k < int'(CENT_NUM); k++) cent[k] <= '0;
      ram_addr       <= '0;
      err            <= 1'b0;
      done           <= 1'b0;
      first_ram_addr <= '0;
      last_ram_addr  <= '0;
      ram_wr_addr    <= '0;
      ram_wr_data    <= '0;
      ram_wr_strobe  <= 1'b0;
      go             <= 1'b0;
      busy           <= 1'b0;
      irq            <= 1'b0;
      host_rdata     <= '0;
      host_rvalid    <= 1'b0;
    end else begin
      go            <= 1'b0;
      ram_wr_strobe <= 1'b0;
      host_rvalid   <= host_rd_en;
      if (host_rd_en) host_rdata <= view[host_addr];

      case (state)
        IDLE, DONE: begin
          if (host_wr_en && host_addr == R_GO && host_wdata[0]) begin
            if (first_ram_addr <= last_ram_addr) begin
              state <= START;
              go    <= 1'b1;
              busy  <= 1'b1;
              err   <= 1'b0;
              done  <= 1'b0;
              irq   <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end else if (host_wr_en && host_addr == R_STATUS && host_wdata[1]) begin
            state <= IDLE;
            done  <= 1'b0;
            irq   <= 1'b0;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (ctl_interrupt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            irq   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Host data writes; while a run is active they are refused and flagged.
      if (host_wr_en && !collide) begin
        if (busy) begin
          if (locked_reg) err <= 1'b1;
        end else begin
          for (int k = 0; k < int'(CENT_NUM); k++)
            if (host_addr == REG_W'(k + 2)) cent[k] <= host_wdata;
          case (host_addr)
            R_RAM_ADDR: ram_addr <= host_wdata[ADDR_W-1:0];
            R_RAM_DATA: begin
              ram_wr_data   <= host_wdata;
              ram_wr_addr   <= ram_addr;
              ram_wr_strobe <= 1'b1;
              ram_addr      <= ram_addr + ADDR_W'(1);
            end
            R_FIRST: first_ram_addr <= host_wdata[ADDR_W-1:0];
            R_LAST:  last_ram_addr  <= host_wdata[ADDR_W-1:0];
            default: ;
          endcase
        end
      end

      for (int k = 0; k < int'(CENT_NUM); k++)
        if (ctl_reg_write && ctl_reg_num == REG_W'(k + 2)) cent[k] <= ctl_wdata;
    end
  end

endmodule

// File: tb/tb_kmeans_regfile.sv
// Randomized self-checking bench for kmeans_regfile against a register-level
// model of the host map, run sequencing and point-RAM loader.
module tb_kmeans_regfile;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned DATA_W   = 91;
  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned CENT_NUM = 8;
  localparam int          RAM_SZ   = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_W-1:0]  host_addr;
  logic              host_wr_en;
  logic              host_rd_en;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic [REG_W-1:0]  ctl_reg_num;
  logic              ctl_reg_write;
  logic [DATA_W-1:0] ctl_wdata;
  logic [DATA_W-1:0] ctl_rdata;
  logic              ctl_interrupt;
  logic              go;
  logic [ADDR_W-1:0] first_ram_addr;
  logic [ADDR_W-1:0] last_ram_addr;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              ram_wr_strobe;
  logic              irq;
  logic              busy;

  kmeans_regfile #(.REG_W(REG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CENT_NUM(CENT_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_addr(host_addr), .host_wr_en(host_wr_en), .host_rd_en(host_rd_en),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ctl_reg_num(ctl_reg_num), .ctl_reg_write(ctl_reg_write), .ctl_wdata(ctl_wdata),
    .ctl_rdata(ctl_rdata), .ctl_interrupt(ctl_interrupt), .go(go),
    .first_ram_addr(first_ram_addr), .last_ram_addr(last_ram_addr),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_strobe(ram_wr_strobe),
    .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: register contents and run status as the host sees them.
  logic [DATA_W-1:0] cent_m [CENT_NUM];
  logic [DATA_W-1:0] ram_data_m;
  int  first_m, last_m, ram_addr_m;
  bit  err_m, done_m, run_m, went_m;
  int  passed = 0;
  int  total  = 0;

  logic [DATA_W-1:0] rd;
  logic              rv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] m_read(input int a);
    if (a == 0) return DATA_W'({err_m, done_m, run_m});
    if (a >= 2 && a <= 9) return cent_m[a-2];
    if (a == 10) return DATA_W'(ram_addr_m);
    if (a == 11) return ram_data_m;
    if (a == 12) return DATA_W'(first_m);
    if (a == 13) return DATA_W'(last_m);
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(CENT_NUM); i++) cent_m[i] = '0;
    ram_data_m = '0;
    first_m = 0; last_m = 0; ram_addr_m = 0;
    err_m = 0; done_m = 0; run_m = 0;
  endtask

  // Drives one host write cycle and applies the map's rules to the model.
  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    host_addr = REG_W'(a); host_wdata = d; host_wr_en = 1'b1;
    tick();
    host_wr_en = 1'b0;
    went_m = 0;
    if (run_m) begin
      if (a >= 1 && a <= 13) err_m = 1;
    end else if (a == 0) begin
      if (d[1]) done_m = 0;
    end else if (a == 1) begin
      if (d[0]) begin
        if (first_m <= last_m) begin
          went_m = 1; err_m = 0; done_m = 0; run_m = 1;
        end else err_m = 1;
      end
    end else if (a >= 2 && a <= 9) cent_m[a-2] = d;
    else if (a == 10) ram_addr_m = int'(d[ADDR_W-1:0]);
    else if (a == 11) begin
      ram_data_m = d;
      ram_addr_m = (ram_addr_m + 1) % RAM_SZ;
    end
    else if (a == 12) first_m = int'(d[ADDR_W-1:0]);
    else if (a == 13) last_m = int'(d[ADDR_W-1:0]);
  endtask

  task automatic do_read(input int a, output logic [DATA_W-1:0] d, output logic v);
    host_addr = REG_W'(a); host_rd_en = 1'b1;
    tick();
    host_rd_en = 1'b0;
    d = host_rdata; v = host_rvalid;
  endtask

  task automatic pulse_interrupt();
    ctl_interrupt = 1'b1;
    tick();
    ctl_interrupt = 1'b0;
    if (run_m) begin run_m = 0; done_m = 1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    ctl_reg_num = REG_W'(2); #1;
    total++; if ({go, busy, irq, ram_wr_strobe, host_rvalid} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {go, busy, irq, ram_wr_strobe, host_rvalid}); else passed++;
    total++; if ({first_ram_addr, last_ram_addr, ram_wr_addr} !== '0) $display("FAIL reset_addrs got %h %h %h want 0", first_ram_addr, last_ram_addr, ram_wr_addr); else passed++;
    total++; if (host_rdata !== '0 || ram_wr_data !== '0) $display("FAIL reset_data got %h %h want 0", host_rdata, ram_wr_data); else passed++;
    total++; if (ctl_rdata !== '0) $display("FAIL reset_cent got %h want 0", ctl_rdata); else passed++;
  endtask

  task automatic test_run();
    int f, l;
    for (int i = 0; i < int'(CENT_NUM); i++) do_write(i + 2, rand_data());
    f = $urandom_range(0, 200);
    l = f + $urandom_range(0, 300);
    do_write(12, DATA_W'(f));
    do_write(13, DATA_W'(l));
    do_write(1, DATA_W'(1));
    total++; if (go !== went_m || busy !== 1'b1) $display("FAIL run_go_start got go=%b busy=%b want go=%b busy=1", go, busy, went_m); else passed++;
    tick();
    total++; if (go !== 1'b0 || busy !== 1'b1) $display("FAIL run_go_single got go=%b busy=%b want go=0 busy=1", go, busy); else passed++;
    total++; if (first_ram_addr !== ADDR_W'(f) || last_ram_addr !== ADDR_W'(l)) $display("FAIL run_window got %0d..%0d want %0d..%0d", first_ram_addr, last_ram_addr, f, l); else passed++;
    for (int i = 0; i < int'(CENT_NUM); i++) begin
      ctl_reg_num = REG_W'(i + 2); #1;
      total++; if (ctl_rdata !== cent_m[i]) $display("FAIL ctl_read_%0d got %h want %h", i + 2, ctl_rdata, cent_m[i]); else passed++;
    end
    for (int i = 0; i < int'(CENT_NUM); i++) begin
      ctl_reg_num = REG_W'(i + 2); ctl_wdata = DATA_W'(32'h100 + i); ctl_reg_write = 1'b1;
      tick();
      cent_m[i] = DATA_W'(32'h100 + i);
    end
    ctl_reg_write = 1'b0;
    pulse_interrupt();
    total++; if (busy !== 1'b0 || irq !== 1'b1) $display("FAIL run_complete got busy=%b irq=%b want busy=0 irq=1", busy, irq); else passed++;
    do_read(0, rd, rv);
    total++; if (rd !== m_read(0) || rv !== 1'b1) $display("FAIL status_done got %h v=%b want %h v=1", rd, rv, m_read(0)); else passed++;
    do_read(4, rd, rv);
    total++; if (rd !== m_read(4) || rv !== 1'b1) $display("FAIL read_cent3 got %h v=%b want %h v=1", rd, rv, m_read(4)); else passed++;
    tick();
    total++; if (host_rvalid !== 1'b0 || host_rdata !== m_read(4)) $display("FAIL rdata_hold got %h v=%b want %h v=0", host_rdata, host_rvalid, m_read(4)); else passed++;
    pulse_interrupt();
    total++; if (irq !== 1'b1 || busy !== 1'b0) $display("FAIL stray_int_done got irq=%b busy=%b want irq=1 busy=0", irq, busy); else passed++;
    do_write(0, DATA_W'(2));
    total++; if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq); else passed++;
    do_read(0, rd, rv);
    total++; if (rd !== m_read(0)) $display("FAIL status_idle got %h want %h", rd, m_read(0)); else passed++;
  endtask

  task automatic test_err();
    int f, l;
    f = $urandom_range(100, 300);
    l = $urandom_range(0, f - 1);
    do_write(12, DATA_W'(f));
    do_write(13, DATA_W'(l));
    do_write(1, DATA_W'(1));
    total++; if (go !== went_m) $display("FAIL bad_window_go got %b want %b", go, went_m); else passed++;
    tick();
    total++; if (go !== 1'b0 || busy !== 1'b0) $display("FAIL bad_window_idle got go=%b busy=%b want 0 0", go, busy); else passed++;
    do_read(0, rd, rv);
    total++; if (rd !== m_read(0)) $display("FAIL status_err got %h want %h", rd, m_read(0)); else passed++;
    l = f + $urandom_range(0, 100);
    do_write(13, DATA_W'(l));
    do_write(1, DATA_W'(1));
    total++; if (go !== went_m || go !== 1'b1) $display("FAIL fixed_window_go got %b want 1", go); else passed++;
    do_read(0, rd, rv);
    total++; if (rd !== m_read(0)) $display("FAIL status_err_cleared got %h want %h", rd, m_read(0)); else passed++;
    tick();
    pulse_interrupt();
    do_write(0, DATA_W'(2));
  endtask

  task automatic test_ram();
    logic [DATA_W-1:0] d;
    int base, n;
    for (int it = 0; it < 4; it++) begin
      base = (it == 0) ? RAM_SZ - 1 : int'($urandom_range(0, RAM_SZ - 1));
      n    = (it == 0) ? 2 : int'($urandom_range(1, 4));
      do_write(10, DATA_W'(base));
      for (int j = 0; j < n; j++) begin
        d = rand_data();
        host_addr = REG_W'(11); host_wdata = d; host_wr_en = 1'b1;
        tick();
        total++; if (ram_wr_strobe !== 1'b1 || ram_wr_addr !== ADDR_W'((base + j) % RAM_SZ) || ram_wr_data !== d)
          $display("FAIL ram_wr_%0d_%0d got s=%b a=%0d d=%h want s=1 a=%0d d=%h", it, j, ram_wr_strobe, ram_wr_addr, ram_wr_data, (base + j) % RAM_SZ, d); else passed++;
        ram_data_m = d;
      end
      host_wr_en = 1'b0;
      ram_addr_m = (base + n) % RAM_SZ;
      tick();
      total++; if (ram_wr_strobe !== 1'b0) $display("FAIL ram_strobe_end_%0d got 1 want 0", it); else passed++;
      do_read(10, rd, rv);
      total++; if (rd !== m_read(10)) $display("FAIL ram_addr_rb_%0d got %h want %h", it, rd, m_read(10)); else passed++;
    end
  endtask

  task automatic test_drop();
    logic [DATA_W-1:0] hx, cy, nf;
    hx = rand_data(); cy = rand_data();
    host_addr = REG_W'(5); host_wdata = hx; host_wr_en = 1'b1;
    ctl_reg_num = REG_W'(5); ctl_wdata = cy; ctl_reg_write = 1'b1;
    tick();
    host_wr_en = 1'b0; ctl_reg_write = 1'b0;
    cent_m[3] = cy;
    do_read(5, rd, rv);
    total++; if (rd !== m_read(5)) $display("FAIL collide_ctl_wins got %h want %h", rd, m_read(5)); else passed++;
    do_read(0, rd, rv);
    total++; if (rd !== m_read(0)) $display("FAIL collide_no_err got %h want %h", rd, m_read(0)); else passed++;
    nf = DATA_W'($urandom_range(0, 50)) | (DATA_W'(1) << 60);
    host_addr = REG_W'(12); host_wdata = nf; host_wr_en = 1'b1; host_rd_en = 1'b1;
    tick();
    host_wr_en = 1'b0; host_rd_en = 1'b0;
    total++; if (host_rdata !== m_read(12)) $display("FAIL read_pre_write got %h want %h", host_rdata, m_read(12)); else passed++;
    first_m = int'(nf[ADDR_W-1:0]);
    do_read(12, rd, rv);
    total++; if (rd !== m_read(12)) $display("FAIL first_upper_bits got %h want %h", rd, m_read(12)); else passed++;
    do_write(13, DATA_W'(first_m + int'($urandom_range(0, 200))));
    do_write(1, DATA_W'(1));
    tick();
    do_write(2, DATA_W'(8'hAA));
    do_write(11, rand_data());
    total++; if (ram_wr_strobe !== 1'b0) $display("FAIL run_ram_drop got 1 want 0"); else passed++;
    do_read(2, rd, rv);
    total++; if (rd !== m_read(2)) $display("FAIL run_cent_drop got %h want %h", rd, m_read(2)); else passed++;
    do_read(0, rd, rv);
    total++; if (rd !== m_read(0)) $display("FAIL status_run_err got %h want %h", rd, m_read(0)); else passed++;
    pulse_interrupt();
    do_write(0, DATA_W'(2));
  endtask

  task automatic test_unmapped();
    do_write(15, rand_data());
    do_read(15, rd, rv);
    total++; if (rd !== '0 || rv !== 1'b1) $display("FAIL unmapped_read got %h v=%b want 0 v=1", rd, rv); else passed++;
    ctl_reg_num = REG_W'(14); #1;
    total++; if (ctl_rdata !== '0) $display("FAIL ctl_unmapped got %h want 0", ctl_rdata); else passed++;
    do_read(1, rd, rv);
    total++; if (rd !== '0) $display("FAIL go_reads_zero got %h want 0", rd); else passed++;
  endtask

  task automatic test_reset_mid_run();
    do_write(12, DATA_W'(0));
    do_write(13, DATA_W'($urandom_range(1, 511)));
    do_write(1, DATA_W'(1));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    ctl_reg_num = REG_W'(2); #1;
    total++; if ({go, busy, irq, ram_wr_strobe, host_rvalid} !== 5'b0) $display("FAIL midrun_reset_flags got %b want 00000", {go, busy, irq, ram_wr_strobe, host_rvalid}); else passed++;
    total++; if (first_ram_addr !== '0 || last_ram_addr !== '0 || ctl_rdata !== '0) $display("FAIL midrun_reset_regs got %h %h %h want 0", first_ram_addr, last_ram_addr, ctl_rdata); else passed++;
    pulse_interrupt();
    total++; if (irq !== 1'b0 || busy !== 1'b0) $display("FAIL post_reset_int got irq=%b busy=%b want 0 0", irq, busy); else passed++;
    do_read(0, rd, rv);
    total++; if (rd !== m_read(0)) $display("FAIL post_reset_status got %h want %h", rd, m_read(0)); else passed++;
    do_write(1, DATA_W'(1));
    total++; if (go !== went_m || go !== 1'b1) $display("FAIL post_reset_go got %b want 1", go); else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; host_addr = '0; host_wr_en = 1'b0; host_rd_en = 1'b0; host_wdata = '0;
    ctl_reg_num = '0; ctl_reg_write = 1'b0; ctl_wdata = '0; ctl_interrupt = 1'b0;
    model_reset();
    test_reset();
    test_run();
    test_err();
    test_ram();
    test_drop();
    test_unmapped();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
